// File: rtl/debounce_edge_detect.sv
// debounce_edge_detect
//
// Conditioning front end for bouncy asynchronous inputs such as push-buttons
// and switches. The raw input passes through a synchroniser chain. A
// consecutive-sample stability counter then filters it. The block produces a
// clean registered level and one-cycle rise/fall pulses. Downstream
// single-bit register stages can sample these pulses directly.
//
// Parameters:
//   SYNC_STAGES   - number of synchroniser flops (2..4)
//   STABLE_CYCLES - consecutive differing samples needed to accept a new
//                   level (1..65535)
//   GLITCH_W      - width of the saturating rejected-glitch counter
//
// Ports:
//   clk          in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   din          in   raw asynchronous input (feeds only the first sync flop)
//   enable       in   filter enable; the synchroniser runs regardless
//   level_out    out  debounced level (registered)
//   rise_pulse   out  one-cycle pulse when a 0->1 change is accepted
//   fall_pulse   out  one-cycle pulse when a 1->0 change is accepted
//   busy         out  a candidate change is being counted
//   glitch_count out  number of rejected candidate changes, saturating

module debounce_edge_detect #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int GLITCH_W      = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                din,
    input  logic                enable,
    output logic                level_out,
    output logic                rise_pulse,
    output logic                fall_pulse,
    output logic                busy,
    output logic [GLITCH_W-1:0] glitch_count
);

    // The counter only has to reach STABLE_CYCLES-1. $clog2(1) is 0, so the
    // width is forced to at least one bit.
    localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

    logic [SYNC_STAGES-1:0] sync_chain_q;
    logic                   sync_q;

    logic                   level_q,  level_d;
    logic                   rise_q,   rise_d;
    logic                   fall_q,   fall_d;
    logic [CNT_W-1:0]       cnt_q,    cnt_d;
    logic [GLITCH_W-1:0]    glitch_q, glitch_d;

    // Synchroniser shift chain. It keeps running while the filter is
    // disabled, so the filter sees an up-to-date sample on re-enable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_chain_q <= '0;
        end else begin
            sync_chain_q <= {sync_chain_q[SYNC_STAGES-2:0], din};
        end
    end

    assign sync_q = sync_chain_q[SYNC_STAGES-1];

    // Stability filter next-state logic.
    // A sample that agrees with the current level while a count is running
    // ends that candidate change, and the candidate is counted as a glitch.
    // When STABLE_CYCLES is 1, CNT_LAST is 0. Any disagreeing sample is then
    // accepted at once, and the counter never leaves zero.
    always_comb begin
        level_d  = level_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        cnt_d    = cnt_q;
        glitch_d = glitch_q;

        if (!enable) begin
            cnt_d = '0;
        end else if (sync_q == level_q) begin
            if (cnt_q != '0) begin
                cnt_d = '0;
                if (glitch_q != GLITCH_MAX) begin
                    glitch_d = glitch_q + GLITCH_W'(1);
                end
            end
        end else if (cnt_q == CNT_LAST) begin
            level_d = sync_q;
            cnt_d   = '0;
            rise_d  = sync_q;
            fall_d  = ~sync_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Filter state registers. The pulses are registered alongside the level,
    // so a pulse appears in the same cycle that level_out changes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_q  <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            cnt_q    <= '0;
            glitch_q <= '0;
        end else begin
            level_q  <= level_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            cnt_q    <= cnt_d;
            glitch_q <= glitch_d;
        end
    end

    assign level_out    = level_q;
    assign rise_pulse   = rise_q;
    assign fall_pulse   = fall_q;
    assign busy         = (cnt_q != '0);
    assign glitch_count = glitch_q;

endmodule

// File: tb/tb_debounce_edge_detect.sv
// tb_debounce_edge_detect
//
// Self-checking bench for debounce_edge_detect at default parameters.
// A reference model checks every cycle. The model describes the filter
// behaviour directly:
//   - the synchronised sample is din delayed by SYNC_STAGES edges;
//   - a run of consecutive samples that differ from the level is counted;
//   - a run reaching STABLE_CYCLES flips the level;
//   - a run broken early counts as a glitch.
// The bench runs directed scenarios and then a randomized phase.

module tb_debounce_edge_detect;

    localparam int SYNC_STAGES   = 2;
    localparam int STABLE_CYCLES = 4;
    localparam int GLITCH_W      = 8;
    localparam int GLITCH_SAT    = (1 << GLITCH_W) - 1;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                din;
    logic                enable;
    logic                level_out;
    logic                rise_pulse;
    logic                fall_pulse;
    logic                busy;
    logic [GLITCH_W-1:0] glitch_count;

    int testsRun    = 0;
    int testsFailed = 0;

    // Reference model state.
    bit mDelay[$];
    int mRun;
    bit mLevel;
    bit mRise;
    bit mFall;
    int mGlitch;

    debounce_edge_detect #(
        .SYNC_STAGES  (SYNC_STAGES),
        .STABLE_CYCLES(STABLE_CYCLES),
        .GLITCH_W     (GLITCH_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .din         (din),
        .enable      (enable),
        .level_out   (level_out),
        .rise_pulse  (rise_pulse),
        .fall_pulse  (fall_pulse),
        .busy        (busy),
        .glitch_count(glitch_count)
    );

    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic void modelReset();
        mDelay.delete();
        for (int i = 0; i < SYNC_STAGES; i++) mDelay.push_back(1'b0);
        mRun    = 0;
        mLevel  = 1'b0;
        mRise   = 1'b0;
        mFall   = 1'b0;
        mGlitch = 0;
    endfunction

    // One rising edge of the model, given the inputs present before the edge.
    function automatic void modelStep(input bit d, input bit en);
        bit sample;
        sample = mDelay.pop_front();
        mDelay.push_back(d);
        mRise = 1'b0;
        mFall = 1'b0;
        if (!en) begin
            mRun = 0;
        end else if (sample != mLevel) begin
            mRun++;
            if (mRun == STABLE_CYCLES) begin
                mLevel = sample;
                mRun   = 0;
                if (sample) mRise = 1'b1;
                else        mFall = 1'b1;
            end
        end else begin
            if (mRun != 0 && mGlitch < GLITCH_SAT) mGlitch++;
            mRun = 0;
        end
    endfunction

    task automatic compareAll(input string tag);
        checkOutput({tag, ".level"},  level_out,    mLevel);
        checkOutput({tag, ".rise"},   rise_pulse,   mRise);
        checkOutput({tag, ".fall"},   fall_pulse,   mFall);
        checkOutput({tag, ".busy"},   busy,         (mRun != 0));
        checkOutput({tag, ".glitch"}, glitch_count, mGlitch);
    endtask

    // Called at a falling edge. It drives the inputs, lets one rising edge
    // pass, and checks the outputs at the following falling edge.
    task automatic applyStimulus(input bit d, input bit en, input string tag);
        din    = d;
        enable = en;
        @(posedge clk);
        modelStep(d, en);
        @(negedge clk);
        compareAll(tag);
    endtask

    // Called at a falling edge. The next rising edge after return is edge 1.
    task automatic doReset(input bit dinDuring);
        reset_n = 1'b0;
        din     = dinDuring;
        enable  = 1'b1;
        modelReset();
        #1;
        compareAll("reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int holdLeft;
        bit rDin;
        bit rEn;

        reset_n = 1'b0;
        din     = 1'b0;
        enable  = 1'b1;
        modelReset();
        @(negedge clk);

        // Idle after reset with din low.
        doReset(1'b0);
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b1, "idle");
        checkOutput("idle_level", level_out, 0);

        // Clean rise: the level and pulse appear after edge 6.
        for (int e = 1; e <= 7; e++) begin
            applyStimulus(1'b1, 1'b1, "rise");
            if (e >= 3 && e <= 5) checkOutput("rise_busy", busy, 1);
            if (e == 5) checkOutput("rise_level_e5", level_out, 0);
            if (e == 6) begin
                checkOutput("rise_level_e6", level_out, 1);
                checkOutput("rise_pulse_e6", rise_pulse, 1);
            end
            if (e == 7) checkOutput("rise_pulse_e7", rise_pulse, 0);
        end

        // A three-edge pulse on din is rejected as a glitch.
        doReset(1'b0);
        for (int e = 1; e <= 8; e++) begin
            applyStimulus((e <= 3), 1'b1, "glitch");
            if (e == 6) begin
                checkOutput("glitch_busy_e6", busy, 0);
                checkOutput("glitch_cnt_e6", glitch_count, 1);
                checkOutput("glitch_level_e6", level_out, 0);
            end
        end

        // Rise to a stable 1, then fall. After that, a long burst of glitches
        // with din nominally low drives the glitch counter to saturation.
        for (int e = 1; e <= 8; e++) applyStimulus(1'b1, 1'b1, "pre_fall");
        for (int e = 1; e <= 7; e++) begin
            applyStimulus(1'b0, 1'b1, "fall");
            if (e == 6) begin
                checkOutput("fall_level_e6", level_out, 0);
                checkOutput("fall_pulse_e6", fall_pulse, 1);
            end
            checkOutput("fall_no_rise", rise_pulse, 0);
        end
        for (int g = 0; g < 300; g++) begin
            applyStimulus(1'b1, 1'b1, "sat");
            for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, "sat");
        end
        checkOutput("glitch_saturated", glitch_count, GLITCH_SAT);

        // Enable is dropped for edges 5-8 while din is held high.
        doReset(1'b0);
        for (int e = 1; e <= 13; e++) begin
            applyStimulus(1'b1, !(e >= 5 && e <= 8), "enable");
            if (e >= 5 && e <= 8) checkOutput("dis_busy", busy, 0);
            if (e == 11) checkOutput("reen_level_e11", level_out, 0);
            if (e == 12) begin
                checkOutput("reen_level_e12", level_out, 1);
                checkOutput("reen_rise_e12", rise_pulse, 1);
            end
        end

        // Reset asserted in the middle of a count.
        doReset(1'b1);
        for (int e = 1; e <= 4; e++) applyStimulus(1'b1, 1'b1, "prereset");
        checkOutput("prereset_busy", busy, 1);
        #2;
        reset_n = 1'b0;
        modelReset();
        #1;
        compareAll("midreset");
        @(negedge clk);
        reset_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            applyStimulus(1'b1, 1'b1, "postreset");
            if (e == 6) checkOutput("postreset_rise_e6", rise_pulse, 1);
        end

        // Randomized phase. Run lengths are mixed so that both accepted
        // changes and rejected glitches occur. Enable drops and resets are
        // occasional.
        doReset(1'b0);
        holdLeft = 0;
        rDin     = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (holdLeft == 0) begin
                rDin     = ~rDin;
                holdLeft = $urandom_range(1, 9);
            end
            holdLeft--;
            rEn = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 799) == 0) begin
                doReset($urandom_range(0, 1) == 1);
            end else begin
                applyStimulus(rDin, rEn, "random");
                checkOutput("random_onehot", (rise_pulse && fall_pulse), 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
